apb_reg_bridge: RTL and testbench
=================================

Name: apb_reg_bridge

Overview:
Parametrised APB slave front-end that converts APB transfers into a request/acknowledge register-bus access for peripheral register files (UART, timers, GPIO).
- Generalises the UART's fixed byte-register, zero-wait-state decoder.
- Configurable register width and register count.
- Supports peripherals that stall through a req/ack handshake, with a timeout.
- Registered response path: one bridge per peripheral slot on the APB fabric.

Parameters:
REG_AW, 3, register index width; 2**REG_AW registers.
REG_BYTES, 1, register width in bytes; legal values 1, 2, 4.
TIMEOUT, 16, max cycles reg_req may wait for reg_ack before error; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
psel  in  1  APB select
penable  in  1  APB enable
pready  out  1  APB ready (registered)
paddr  in  12  APB byte address
pwrite  in  1  APB direction, 1 = write
pwdata  in  32  APB write data
pwstrb  in  4  APB write strobes
prdata  out  32  APB read data (registered)
pslverr  out  1  APB error (registered)
reg_req  out  1  register access request, held until ack or timeout
reg_write  out  1  request is a write
reg_addr  out  REG_AW  register index
reg_wdata  out  8*REG_BYTES  register write data
reg_ack  in  1  peripheral completes request; may be high in the first reg_req cycle
reg_rdata  in  8*REG_BYTES  read data, valid with reg_ack
reg_err  in  1  peripheral error, valid with reg_ack

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high.
- Reset: state IDLE, timeout counter 0, all outputs 0 (pready=0, pslverr=0, prdata=0, reg_req=0). Reset during WAIT drops reg_req from the next cycle; the pending APB transfer is abandoned.
- Decode (LB = log2(REG_BYTES)):
  - index = paddr[LB +: REG_AW].
  - out_of_range = |paddr[11 : LB+REG_AW].
  - misaligned = paddr[LB-1:0] != 0 (never set when REG_BYTES=1).
  - lane = paddr[1:0] & ~(REG_BYTES-1).
  - Expected strobe = ((1<<REG_BYTES)-1) << lane.
  - wrong_strb = pwrite & (pwstrb != expected).
  - pwstrb is ignored on reads.
  - dec_err = out_of_range | misaligned | wrong_strb.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On psel & penable with dec_err: go to RESP, pslverr=1, prdata=0, no reg_req.
  - On psel & penable without dec_err: latch reg_addr=index, reg_write=pwrite, reg_wdata=pwdata[8*lane +: 8*REG_BYTES], and lane; go to WAIT.
  - The setup phase (psel & ~penable) is ignored.
- WAIT:
  - reg_req=1; reg_addr, reg_write and reg_wdata held stable.
  - Counter increments each WAIT cycle.
  - If reg_ack: capture prdata = zero-extended reg_rdata << (8*lane) (zeros for writes) and pslverr = reg_err; go to RESP.
  - Else if TIMEOUT != 0 and counter == TIMEOUT-1: pslverr=1, prdata=0; go to RESP. reg_req is therefore high for exactly TIMEOUT cycles.
  - reg_ack outside WAIT is ignored.
- RESP:
  - pready=1 for exactly one cycle, with prdata and pslverr valid.
  - Then clear pready/prdata/pslverr to 0, clear the counter, return to IDLE.
- Latency: with the access phase at cycle T and immediate ack, reg_req is high at T+1 and pready at T+2. An ack after k WAIT cycles gives pready at T+1+k. A decode error gives pready at T+1.
- psel/penable dropping during WAIT is a protocol violation: the access still completes and RESP is still issued. No new transfer is accepted until back in IDLE.
- pready, pslverr and prdata are 0 in IDLE and WAIT.

Test Plan:
- REG_BYTES=1, write paddr=0x005, pwstrb=0010, pwdata=0x0000AB00, ack in first WAIT cycle -> reg_req 1 cycle, reg_write=1, reg_addr=5, reg_wdata=0xAB; pready at T+2, pslverr=0.
- REG_BYTES=1, read paddr=0x007, ack after 3 WAIT cycles with reg_rdata=0x5C -> prdata=0x5C000000, pready at T+4, pslverr=0.
- Decode errors: paddr=0x010 (out of range); write paddr=0x002 with pwstrb=0001 -> pslverr=1, pready at T+1, reg_req never asserted.
- TIMEOUT=4, no ack -> reg_req high exactly 4 cycles, then pready=1, pslverr=1, prdata=0.
- REG_BYTES=4:
  - read paddr=0x008, reg_rdata=0xDEADBEEF -> reg_addr=2, prdata=0xDEADBEEF.
  - paddr=0x00A -> misalign error.
  - reg_err=1 with ack -> pslverr=1.
- rst asserted during the second WAIT cycle -> reg_req=0 the next cycle, no pready, outputs 0; a fresh transfer afterwards completes normally.

Source files
------------

// File: rtl/apb_reg_bridge.sv
// APB slave front-end driving a req/ack register bus.
// Registered APB response path with an optional ack timeout.
module apb_reg_bridge #(
  parameter int REG_AW    = 3,
  parameter int REG_BYTES = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   psel,
  input  logic                   penable,
  output logic                   pready,
  input  logic [11:0]            paddr,
  input  logic                   pwrite,
  input  logic [31:0]            pwdata,
  input  logic [3:0]             pwstrb,
  output logic [31:0]            prdata,
  output logic                   pslverr,
  output logic                   reg_req,
  output logic                   reg_write,
  output logic [REG_AW-1:0]      reg_addr,
  output logic [8*REG_BYTES-1:0] reg_wdata,
  input  logic                   reg_ack,
  input  logic [8*REG_BYTES-1:0] reg_rdata,
  input  logic                   reg_err
);

  localparam int LB = (REG_BYTES == 4) ? 2 :
                      (REG_BYTES == 2) ? 1 : 0;
  localparam int DW = 8 * REG_BYTES;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TLAST = CW'(TL);
  localparam logic [1:0] LMASK = 2'(REG_BYTES - 1);
  localparam logic [3:0] SMASK = 4'((1 << REG_BYTES) - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_n;

  logic [CW-1:0]     cnt, cnt_n;
  logic [1:0]        lane, lane_n;
  logic [REG_AW-1:0] addr_n;
  logic              write_n;
  logic [DW-1:0]     wdata_n;
  logic              pready_n;
  logic              pslverr_n;
  logic [31:0]       prdata_n;

  logic [REG_AW-1:0] index;
  logic [1:0]        dec_lane;
  logic [3:0]        exp_strb;
  logic              out_of_range;
  logic              misaligned;
  logic              wrong_strb;
  logic              dec_err;
  logic              tmo;
  logic [DW-1:0]     wd_sel;
  logic [31:0]       rd_ext;

  assign index        = paddr[LB +: REG_AW];
  assign out_of_range = (paddr >> (LB + REG_AW)) != '0;
  assign misaligned   = (paddr[1:0] & LMASK) != 2'b00;
  assign dec_lane     = paddr[1:0] & ~LMASK;
  assign exp_strb     = SMASK << dec_lane;
  assign wrong_strb   = pwrite && (pwstrb != exp_strb);
  assign dec_err      = out_of_range | misaligned | wrong_strb;

  // byte lane steering in both directions
  assign wd_sel = DW'(pwdata >> {dec_lane, 3'b000});
  assign rd_ext = 32'(reg_rdata) << {lane, 3'b000};

  assign tmo     = (TIMEOUT != 0) && (cnt == TLAST);
  assign reg_req = (state == WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lane      <= '0;
      reg_addr  <= '0;
      reg_write <= 1'b0;
      reg_wdata <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      prdata    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      lane      <= lane_n;
      reg_addr  <= addr_n;
      reg_write <= write_n;
      reg_wdata <= wdata_n;
      pready    <= pready_n;
      pslverr   <= pslverr_n;
      prdata    <= prdata_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lane_n    = lane;
    addr_n    = reg_addr;
    write_n   = reg_write;
    wdata_n   = reg_wdata;
    pready_n  = 1'b0;
    pslverr_n = 1'b0;
    prdata_n  = '0;
    unique case (state)
      IDLE: begin
        if (psel && penable) begin
          if (dec_err) begin
            state_n   = RESP;
            pready_n  = 1'b1;
            pslverr_n = 1'b1;
          end else begin
            state_n = WAIT;
            addr_n  = index;
            write_n = pwrite;
            wdata_n = wd_sel;
            lane_n  = dec_lane;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt + CW'(1);
        if (reg_ack) begin
          state_n   = RESP;
          cnt_n     = '0;
          pready_n  = 1'b1;
          pslverr_n = reg_err;
          prdata_n  = reg_write ? 32'd0 : rd_ext;
        end else if (tmo) begin
          state_n   = RESP;
          cnt_n     = '0;
          pready_n  = 1'b1;
          pslverr_n = 1'b1;
        end
      end
      RESP: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_reg_bridge.sv
// Bench for apb_reg_bridge: byte-wide and word-wide instances,
// table vectors, reset-in-WAIT sequence and a random model check.
module tb_apb_reg_bridge;

  localparam int TO = 4;

  typedef struct {
    int          d;
    logic [11:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          nwait;
    logic [31:0] rdata;
    logic        rerr;
    int          e_req;
    int          e_err;
    logic [31:0] e_prdata;
    int          e_idx;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdy;
    logic [31:0] slv;
    logic [31:0] prd;
    logic [31:0] req;
    logic [31:0] rw;
    logic [31:0] idx;
    logic [31:0] wdata;
  } obs_t;

  logic clk = 1'b0;
  logic rst;

  logic        sel0, en0, wr0, ack0, err0;
  logic [11:0] addr0;
  logic [31:0] wd0;
  logic [3:0]  st0;
  logic [7:0]  rd0;
  logic        rdy0, slv0, req0, rw0;
  logic [31:0] prd0;
  logic [2:0]  ra0;
  logic [7:0]  rwd0;

  logic        sel1, en1, wr1, ack1, err1;
  logic [11:0] addr1;
  logic [31:0] wd1;
  logic [3:0]  st1;
  logic [31:0] rd1;
  logic        rdy1, slv1, req1, rw1;
  logic [31:0] prd1;
  logic [2:0]  ra1;
  logic [31:0] rwd1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  apb_reg_bridge #(
    .REG_AW(3), .REG_BYTES(1), .TIMEOUT(TO)
  ) u_b (
    .clk(clk), .rst(rst),
    .psel(sel0), .penable(en0), .pready(rdy0),
    .paddr(addr0), .pwrite(wr0), .pwdata(wd0),
    .pwstrb(st0), .prdata(prd0), .pslverr(slv0),
    .reg_req(req0), .reg_write(rw0), .reg_addr(ra0),
    .reg_wdata(rwd0), .reg_ack(ack0),
    .reg_rdata(rd0), .reg_err(err0)
  );

  apb_reg_bridge #(
    .REG_AW(3), .REG_BYTES(4), .TIMEOUT(TO)
  ) u_w (
    .clk(clk), .rst(rst),
    .psel(sel1), .penable(en1), .pready(rdy1),
    .paddr(addr1), .pwrite(wr1), .pwdata(wd1),
    .pwstrb(st1), .prdata(prd1), .pslverr(slv1),
    .reg_req(req1), .reg_write(rw1), .reg_addr(ra1),
    .reg_wdata(rwd1), .reg_ack(ack1),
    .reg_rdata(rd1), .reg_err(err1)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(int d, logic s, logic e,
                     logic [11:0] a, logic w,
                     logic [31:0] wd, logic [3:0] st);
    if (d == 0) begin
      sel0 = s; en0 = e; addr0 = a;
      wr0 = w; wd0 = wd; st0 = st;
    end else begin
      sel1 = s; en1 = e; addr1 = a;
      wr1 = w; wd1 = wd; st1 = st;
    end
  endtask

  task automatic set_ack(int d, logic a,
                         logic [31:0] rd, logic e);
    if (d == 0) begin
      ack0 = a; rd0 = rd[7:0]; err0 = e;
    end else begin
      ack1 = a; rd1 = rd; err1 = e;
    end
  endtask

  function automatic obs_t obs(int d);
    obs_t o;
    if (d == 0) begin
      o.rdy = 32'(rdy0); o.slv = 32'(slv0);
      o.prd = prd0; o.req = 32'(req0);
      o.rw = 32'(rw0); o.idx = 32'(ra0);
      o.wdata = 32'(rwd0);
    end else begin
      o.rdy = 32'(rdy1); o.slv = 32'(slv1);
      o.prd = prd1; o.req = 32'(req1);
      o.rw = 32'(rw1); o.idx = 32'(ra1);
      o.wdata = rwd1;
    end
    return o;
  endfunction

  function automatic int lane_of(int d, logic [11:0] a);
    int rb;
    rb = (d == 0) ? 1 : 4;
    return ((int'(a) % 4) / rb) * rb;
  endfunction

  // Expected outcome from the address map and handshake rules
  function automatic vec_t model(vec_t v);
    int rb, ln, a;
    logic [31:0] mask;
    logic [3:0] es;
    logic bad;
    vec_t r;
    r = v;
    rb = (v.d == 0) ? 1 : 4;
    a = int'(v.addr);
    ln = lane_of(v.d, v.addr);
    mask = (rb == 4) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    es = 4'(((1 << rb) - 1) << ln);
    bad = (a / rb >= 8) || (a % rb != 0) ||
          (v.wr && v.strb != es);
    r.e_idx = (a / rb) % 8;
    r.e_wdata = (v.wdata >> (8 * ln)) & mask;
    if (bad) begin
      r.e_req = 0; r.e_err = 1; r.e_prdata = 0;
    end else if (v.nwait <= TO) begin
      r.e_req = v.nwait;
      r.e_err = int'(v.rerr);
      r.e_prdata = v.wr ? 32'd0 :
                   (v.rdata & mask) << (8 * ln);
    end else begin
      r.e_req = TO; r.e_err = 1; r.e_prdata = 0;
    end
    return r;
  endfunction

  task automatic xfer(vec_t v);
    obs_t o;
    @(posedge clk); #1;
    drv(v.d, 1, 0, v.addr, v.wr, v.wdata, v.strb);
    @(posedge clk); #1;
    drv(v.d, 1, 1, v.addr, v.wr, v.wdata, v.strb);
    for (int c = 1; c <= v.e_req + 2; c++) begin
      @(posedge clk); #1;
      if (c <= v.e_req)
        set_ack(v.d, c == v.nwait, v.rdata, v.rerr);
      else
        set_ack(v.d, 1'($urandom), v.rdata, 1'($urandom));
      if (c == v.e_req + 2)
        drv(v.d, 0, 0, v.addr, v.wr, v.wdata, v.strb);
      @(negedge clk);
      o = obs(v.d);
      if (c <= v.e_req) begin
        chk("wait_req", o.req, 1);
        chk("wait_rdy", o.rdy, 0);
        if (c == 1) begin
          chk("reg_addr", o.idx, v.e_idx);
          chk("reg_write", o.rw, 32'(v.wr));
          if (v.wr) chk("reg_wdata", o.wdata, v.e_wdata);
        end
      end else if (c == v.e_req + 1) begin
        chk("resp_rdy", o.rdy, 1);
        chk("resp_req", o.req, 0);
        chk("resp_slverr", o.slv, v.e_err);
        chk("resp_prdata", o.prd, v.e_prdata);
      end else begin
        chk("after_rdy", o.rdy, 0);
        chk("after_req", o.req, 0);
        chk("after_out", o.prd | o.slv, 0);
      end
    end
    set_ack(v.d, 0, 0, 0);
  endtask

  vec_t tbl[12];
  vec_t v;
  obs_t o;

  initial begin
    rst = 1;
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    set_ack(0, 0, 0, 0);
    set_ack(1, 0, 0, 0);

    tbl[0]  = '{0, 12'h005, 1, 32'h0000AB00, 4'b0010, 1,
                0, 0, 1, 0, 0, 5, 32'hAB};
    tbl[1]  = '{0, 12'h007, 0, 0, 0, 3,
                32'h5C, 0, 3, 0, 32'h5C000000, 7, 0};
    tbl[2]  = '{0, 12'h010, 0, 0, 0, 1,
                0, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 12'h002, 1, 32'h11, 4'b0001, 1,
                0, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 12'h001, 0, 0, 0, 9,
                32'h77, 0, 4, 1, 0, 1, 0};
    tbl[5]  = '{1, 12'h008, 0, 0, 0, 1,
                32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF, 2, 0};
    tbl[6]  = '{1, 12'h00A, 0, 0, 0, 1,
                0, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{1, 12'h004, 1, 32'h12345678, 4'hF, 2,
                32'h99, 1, 2, 1, 0, 1, 32'h12345678};
    tbl[8]  = '{1, 12'h01C, 0, 0, 0, 4,
                32'hCAFEF00D, 0, 4, 0, 32'hCAFEF00D, 7, 0};
    tbl[9]  = '{1, 12'h020, 0, 0, 0, 1,
                0, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 12'h003, 1, 32'h7F000000, 4'b1000, 2,
                0, 0, 2, 0, 0, 3, 32'h7F};
    tbl[11] = '{1, 12'h00C, 1, 32'h1, 4'b0111, 1,
                0, 0, 0, 1, 0, 0, 0};

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      o = obs(d);
      chk("rst_rdy", o.rdy, 0);
      chk("rst_req", o.req, 0);
      chk("rst_out", o.prd | o.slv | o.idx | o.wdata, 0);
    end

    foreach (tbl[i]) xfer(tbl[i]);

    // reset during the second WAIT cycle
    @(posedge clk); #1;
    drv(0, 1, 0, 12'h001, 0, 0, 0);
    @(posedge clk); #1;
    drv(0, 1, 1, 12'h001, 0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_req1", 32'(req0), 1);
    @(posedge clk); #1;
    rst = 1;
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rw_req2", 32'(req0), 1);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    o = obs(0);
    chk("rw_req_drop", o.req, 0);
    chk("rw_rdy", o.rdy, 0);
    chk("rw_out", o.prd | o.slv | o.idx, 0);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rw_quiet", 32'(rdy0) | 32'(req0), 0);
    end
    v = '{0, 12'h006, 0, 0, 0, 2,
          32'h3C, 0, 0, 0, 0, 0, 0};
    v = model(v);
    chk("rw_model", v.e_prdata, 32'h003C0000);
    xfer(v);

    // random traffic against the model
    for (int n = 0; n < 120; n++) begin
      int d, rb;
      d = n % 2;
      rb = (d == 0) ? 1 : 4;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        drv(d, 1'($urandom), 0, 12'($urandom),
            1'($urandom), $urandom, 4'($urandom));
        set_ack(d, 1'($urandom), $urandom, 1'($urandom));
        @(negedge clk);
        o = obs(d);
        chk("gap_idle", o.rdy | o.req, 0);
      end
      v.d = d;
      v.addr = ($urandom % 4 != 0) ?
               12'($urandom_range(0, 8 * rb - 1)) :
               12'($urandom);
      v.wr = 1'($urandom);
      v.wdata = $urandom;
      v.strb = ($urandom % 4 != 0) ?
               4'(((1 << rb) - 1) << lane_of(d, v.addr)) :
               4'($urandom);
      v.nwait = $urandom_range(1, 6);
      v.rdata = $urandom;
      v.rerr = ($urandom % 5) == 0;
      v = model(v);
      xfer(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
